// File: rtl/apb4_reg_bridge.sv
// apb4_reg_bridge
//   Bridges an APB4 completer port onto a simple single-cycle register
//   request bus. Each APB transfer is captured in the setup phase, screened
//   for illegal accesses, then issued to the register map as a one-cycle
//   bus_req. The response is registered and returned in the APB access phase.
//   A missing bus_ready is bounded by an optional timeout.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   psel, penable      APB select / access phase
//   pwrite             1 = write
//   paddr              byte address
//   pwdata, pstrb      write data and byte strobes
//   pprot              protection; bit 0 = privileged
//   pready             transfer complete (DONE state only)
//   prdata, pslverr    read data / error (DONE state only)
//   bus_req            one-cycle register request
//   bus_req_is_wr      request is a write
//   bus_addr           request address
//   bus_wr_data        write data
//   bus_wr_biten       per-bit write enable (zero for reads)
//   bus_ready          register map acknowledge
//   bus_err            register map error, valid with bus_ready
//   bus_rd_data        register map read data, valid with bus_ready
//   timeout_pulse      one-cycle timeout event
module apb4_reg_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 11,
   parameter int TIMEOUT_CYCLES = 16,
   parameter bit PRIV_ONLY      = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [2:0]              pprot,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr,
   output logic                    bus_req,
   output logic                    bus_req_is_wr,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH-1:0]   bus_wr_data,
   output logic [DATA_WIDTH-1:0]   bus_wr_biten,
   input  logic                    bus_ready,
   input  logic                    bus_err,
   input  logic [DATA_WIDTH-1:0]   bus_rd_data,
   output logic                    timeout_pulse
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int ALIGN_W = $clog2(STRB_W);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
   // Value of the wait counter during the last WAIT cycle before timing out.
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_W-1:0]       strb_q;
   logic                    is_wr_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    bus_req_q;
   logic                    timeout_q;
   logic                    req_err;
   logic                    unused_prot;

   // Only the privilege bit of pprot matters here.
   assign unused_prot = ^pprot[2:1];

   // Screening of the setup-phase request; the verdict is latched with it.
   always_comb begin
      req_err = 1'b0;
      if (paddr[ALIGN_W-1:0] != '0)
         req_err = 1'b1;
      if (!pwrite && (pstrb != '0))
         req_err = 1'b1;
      if (PRIV_ONLY && !pprot[0])
         req_err = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         is_wr_q   <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         bus_req_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         bus_req_q <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (psel && !penable) begin
                  addr_q    <= paddr;
                  wdata_q   <= pwdata;
                  strb_q    <= pstrb;
                  is_wr_q   <= pwrite;
                  err_q     <= req_err;
                  rdata_q   <= '0;
                  cnt_q     <= '0;
                  // bus_req is registered so it is high exactly during ISSUE.
                  bus_req_q <= !req_err;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               // A screened-out request never reaches the register map,
               // so any bus_ready seen here belongs to nobody.
               if (err_q) begin
                  state_q <= DONE;
               end else if (bus_ready) begin
                  rdata_q <= is_wr_q ? '0 : bus_rd_data;
                  err_q   <= bus_err;
                  state_q <= DONE;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // bus_ready is checked first so it wins over a same-cycle timeout.
               if (bus_ready) begin
                  rdata_q <= is_wr_q ? '0 : bus_rd_data;
                  err_q   <= bus_err;
                  state_q <= DONE;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus_wr_biten = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         bus_wr_biten[i] = is_wr_q & strb_q[i/8];
   end

   // If psel has dropped by DONE, pready stays low and the result is discarded.
   assign pready        = (state_q == DONE) && psel && penable;
   assign prdata        = (state_q == DONE) ? rdata_q : '0;
   assign pslverr       = (state_q == DONE) ? err_q : 1'b0;
   assign bus_req       = bus_req_q;
   assign bus_req_is_wr = is_wr_q;
   assign bus_addr      = addr_q;
   assign bus_wr_data   = wdata_q;
   assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_apb4_reg_bridge.sv
module tb_apb4_reg_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [10:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic        bus_req, bus_req_is_wr;
   logic [10:0] bus_addr;
   logic [31:0] bus_wr_data, bus_wr_biten;
   logic        bus_ready, bus_err;
   logic [31:0] bus_rd_data;
   logic        timeout_pulse;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] prdata;
      logic        slverr;
      logic        to;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   apb4_reg_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(11), .TIMEOUT_CYCLES(TO), .PRIV_ONLY(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
      .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data),
      .timeout_pulse(timeout_pulse)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] biten_of(input logic wr, input logic [3:0] s);
      logic [31:0] b;
      b = '0;
      if (wr)
         for (int k = 0; k < 4; k++)
            if (s[k]) b[8*k +: 8] = 8'hFF;
      return b;
   endfunction

   // One complete APB transfer. rdy_at: cycle after setup at which bus_ready is
   // driven (0 = ISSUE cycle); values above TO mean "never, then late".
   task automatic xfer(input string tag, input logic wr, input logic [10:0] a,
                       input logic [31:0] wd, input logic [3:0] s, input logic [2:0] prot,
                       input int rdy_at, input logic [31:0] rd, input logic be);
      exp_t e, g;
      logic flag, exp_req, late;
      int   c, nreq, nto;
      bit   got, leak;
      flag    = (a[1:0] != 2'b00) || (!wr && (s != 4'h0)) || !prot[0];
      exp_req = !flag;
      late    = 1'b0;
      if (flag) begin
         e.prdata = 32'h0; e.slverr = 1'b1; e.to = 1'b0; e.lat = 3;
      end else if (rdy_at < 0 || rdy_at > TO) begin
         e.prdata = 32'h0; e.slverr = 1'b1; e.to = 1'b1; e.lat = 3 + TO;
         late = (rdy_at > TO);
      end else begin
         e.prdata = wr ? 32'h0 : rd; e.slverr = be; e.to = 1'b0; e.lat = 3 + rdy_at;
      end
      sb.push_back(e);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = s; pprot = prot;
      @(posedge clk); #1;
      penable = 1'b1;
      c = 0; got = 0; leak = 0; nreq = 0; nto = 0;
      while (!got && c < 20) begin
         bus_ready   = (c == rdy_at);
         bus_err     = bus_ready ? be : 1'b0;
         bus_rd_data = bus_ready ? rd : $urandom;
         @(negedge clk);
         nreq += int'(bus_req);
         nto  += int'(timeout_pulse);
         if (c == 0) begin
            chk({tag, "_req_issue"}, bus_req, exp_req);
            chk({tag, "_addr"}, bus_addr, a);
            chk({tag, "_is_wr"}, bus_req_is_wr, wr);
            chk({tag, "_wdata"}, bus_wr_data, wd);
            chk({tag, "_biten"}, bus_wr_biten, biten_of(wr, s));
         end
         if (pready) begin
            got = 1;
            if (sb.size() > 0) begin
               g = sb.pop_front();
               chk({tag, "_prdata"}, prdata, g.prdata);
               chk({tag, "_pslverr"}, pslverr, g.slverr);
               chk({tag, "_latency"}, c + 2, g.lat);
               chk({tag, "_tmo_pulse"}, timeout_pulse, g.to);
            end else begin
               chk({tag, "_sb_empty"}, 1, 0);
            end
         end else if (prdata != 32'h0 || pslverr !== 1'b0) begin
            leak = 1;
         end
         @(posedge clk); #1;
         c++;
      end
      chk({tag, "_got_pready"}, got, 1);
      chk({tag, "_req_count"}, nreq, exp_req);
      chk({tag, "_tmo_count"}, nto, e.to);
      chk({tag, "_idle_zero"}, leak, 0);
      // Idle cycle after the transfer; a late bus_ready here must be ignored.
      psel = 1'b0; penable = 1'b0; bus_ready = late; bus_err = 1'b0;
      @(negedge clk);
      chk({tag, "_post_pready"}, pready, 1'b0);
      chk({tag, "_post_req"}, bus_req, 1'b0);
      @(posedge clk); #1;
      bus_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nrdy;
      int nreq;
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pwdata = '0; pstrb = '0; pprot = 3'b001;
      bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", {pready, pslverr, bus_req, bus_req_is_wr, timeout_pulse}, 5'b0);
      chk("reset_prdata", prdata, 32'h0);
      chk("reset_bus_addr", bus_addr, 11'h0);
      chk("reset_bus_wdata", bus_wr_data, 32'h0);
      chk("reset_biten", bus_wr_biten, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Setup is driven together with reset release: first edge accepts it.
      xfer("wr10",      1'b1, 11'h010, 32'hA5A5_0F0F, 4'b0101, 3'b001, 0,  32'h0,         1'b0);
      xfer("rd20",      1'b0, 11'h020, 32'h0,         4'h0,    3'b001, 3,  32'h1234_5678, 1'b0);
      xfer("rd22_mis",  1'b0, 11'h022, 32'h0,         4'h0,    3'b001, 0,  32'hFFFF_FFFF, 1'b0);
      xfer("rd50_tmo",  1'b0, 11'h050, 32'h0,         4'h0,    3'b001, 99, 32'h55AA_55AA, 1'b0);
      xfer("rd54_race", 1'b0, 11'h054, 32'h0,         4'h0,    3'b001, 4,  32'hCAFE_F00D, 1'b0);
      xfer("wr60_user", 1'b1, 11'h060, 32'h1122_3344, 4'hF,    3'b000, 0,  32'h0,         1'b0);
      xfer("wr60_priv", 1'b1, 11'h060, 32'h1122_3344, 4'hF,    3'b001, 0,  32'h0,         1'b0);
      xfer("rd70_strb", 1'b0, 11'h070, 32'h0,         4'h3,    3'b001, 0,  32'h0000_0009, 1'b0);
      xfer("wr74_nost", 1'b1, 11'h074, 32'h0000_0077, 4'h0,    3'b001, 1,  32'h0,         1'b0);
      xfer("rd78_berr", 1'b0, 11'h078, 32'h0,         4'h0,    3'b011, 2,  32'h600D_F00D, 1'b1);

      // psel withdrawn after setup: bus access completes, no pready.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 11'h030; pstrb = 4'h0; pprot = 3'b001;
      @(posedge clk); #1;
      psel = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
      chk("drop_req", bus_req, 1'b1);
      nrdy = 0;
      @(posedge clk); #1;
      bus_ready = 1'b1; bus_rd_data = 32'h0BAD_0BAD;
      @(negedge clk);
      nrdy += int'(pready);
      @(posedge clk); #1;
      bus_ready = 1'b0;
      @(negedge clk);
      nrdy += int'(pready);
      @(posedge clk); #1;
      @(negedge clk);
      nrdy += int'(pready);
      chk("drop_no_pready", nrdy, 0);
      @(posedge clk); #1;
      xfer("rd34_after_drop", 1'b0, 11'h034, 32'h0, 4'h0, 3'b001, 1, 32'h3434_3434, 1'b0);

      // Reset in the middle of WAIT.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 11'h040;
      pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1'b1; bus_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      chk("midrst_ctl", {pready, pslverr, bus_req, bus_req_is_wr, timeout_pulse}, 5'b0);
      chk("midrst_prdata", prdata, 32'h0);
      chk("midrst_bus_addr", bus_addr, 11'h0);
      chk("midrst_bus_wdata", bus_wr_data, 32'h0);
      chk("midrst_biten", bus_wr_biten, 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      nrdy = 0; nreq = 0;
      repeat (3) begin
         @(negedge clk);
         nrdy += int'(pready);
         nreq += int'(bus_req);
         @(posedge clk); #1;
      end
      chk("midrst_no_pready", nrdy, 0);
      chk("midrst_no_req", nreq, 0);
      xfer("wr44_after_rst", 1'b1, 11'h044, 32'h0F0F_1234, 4'b1010, 3'b001, 0, 32'h0, 1'b0);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
